octant_path_scheduler: RTL and testbench

// - Sequences octree construction over a packed point cloud: walks points 0..size-1, descends MAX_DEPTH levels per point.
// - Emits each point's root-first octant path code to the downstream BRAM/BFS writer over a valid/ready handshake.
// - Sits between the point-cloud input buses and the octant BRAM builder; drives the build's o_finish.

---
 rtl/octant_pkg.sv | 37 +++
 rtl/octant_step.sv | 48 ++++
 rtl/octant_path_scheduler.sv | 175 +++++++++++++++++
 tb/tb_octant_path_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/octant_pkg.sv
// Shared types and field layout for the octree path scheduler.
// Bounds buses pack {x, y, z, pad} from MSB down, 16 bits per field.
package octant_pkg;

    localparam int AXIS_W = 16;
    localparam int X_HI   = 63;
    localparam int Y_HI   = 47;
    localparam int Z_HI   = 31;
    localparam int BOX_W  = 6 * AXIS_W;

    // Octant code bit order: {x, y, z} from MSB to LSB.
    localparam int OCT_X_BIT = 2;
    localparam int OCT_Y_BIT = 1;
    localparam int OCT_Z_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DESCEND = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef struct packed {
        logic signed [AXIS_W-1:0] min_x;
        logic signed [AXIS_W-1:0] min_y;
        logic signed [AXIS_W-1:0] min_z;
        logic signed [AXIS_W-1:0] max_x;
        logic signed [AXIS_W-1:0] max_y;
        logic signed [AXIS_W-1:0] max_z;
    } box_t;

    function automatic logic signed [AXIS_W-1:0] axis_field(input logic [63:0] v, input int hi);
        return v[hi -: AXIS_W];
    endfunction

endpackage

// File: rtl/octant_step.sv
// One level of octree descent: splits the box at its midpoint and picks the
// child octant containing the point. Purely combinational.
module octant_step
    import octant_pkg::*;
(
    input  logic [BOX_W-1:0]  i_box,
    input  logic [AXIS_W-1:0] i_x,
    input  logic [AXIS_W-1:0] i_y,
    input  logic [AXIS_W-1:0] i_z,
    output logic [2:0]        o_oct,
    output logic [BOX_W-1:0]  o_child
);

    box_t box;
    box_t child;
    logic signed [AXIS_W-1:0] mid_x;
    logic signed [AXIS_W-1:0] mid_y;
    logic signed [AXIS_W-1:0] mid_z;

    // Sum in one extra bit so the midpoint never overflows, then floor-halve.
    function automatic logic signed [AXIS_W-1:0] midpoint(
        input logic signed [AXIS_W-1:0] a,
        input logic signed [AXIS_W-1:0] b
    );
        logic signed [AXIS_W:0] sum;
        sum = {a[AXIS_W-1], a} + {b[AXIS_W-1], b};
        return AXIS_W'(sum >>> 1);
    endfunction

    always_comb begin
        box   = box_t'(i_box);
        mid_x = midpoint(box.min_x, box.max_x);
        mid_y = midpoint(box.min_y, box.max_y);
        mid_z = midpoint(box.min_z, box.max_z);

        o_oct            = '0;
        o_oct[OCT_X_BIT] = $signed(i_x) >= mid_x;
        o_oct[OCT_Y_BIT] = $signed(i_y) >= mid_y;
        o_oct[OCT_Z_BIT] = $signed(i_z) >= mid_z;

        child = box;
        if (o_oct[OCT_X_BIT]) child.min_x = mid_x; else child.max_x = mid_x;
        if (o_oct[OCT_Y_BIT]) child.min_y = mid_y; else child.max_y = mid_y;
        if (o_oct[OCT_Z_BIT]) child.min_z = mid_z; else child.max_z = mid_z;
        o_child = child;
    end

endmodule

// File: rtl/octant_path_scheduler.sv
// Walks the packed point cloud, descends MAX_DEPTH octree levels per point and
// hands each root-first octant path downstream over valid/ready.
module octant_path_scheduler
    import octant_pkg::*;
#(
    parameter int MAX_DEPTH = 14,
    parameter int N_MAX     = 7,
    parameter int CNT_W     = 8
)
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [CNT_W-1:0]       i_point_cloud_size,
    input  logic [16*N_MAX-1:0]    i_points_x,
    input  logic [16*N_MAX-1:0]    i_points_y,
    input  logic [16*N_MAX-1:0]    i_points_z,
    input  logic [63:0]            i_near_bottom_left,
    input  logic [63:0]            i_far_top_right,
    output logic [3*MAX_DEPTH-1:0] o_code,
    output logic [CNT_W-1:0]       o_point_idx,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_finish
);

    localparam int CODE_W = 3 * MAX_DEPTH;
    localparam int LVL_W  = $clog2(MAX_DEPTH);

    state_e state_q, state_d;
    logic                armed_q, armed_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [BOX_W-1:0]    bounds_q, bounds_d;
    logic [BOX_W-1:0]    box_q, box_d;
    logic [AXIS_W-1:0]   pt_x_q, pt_x_d;
    logic [AXIS_W-1:0]   pt_y_q, pt_y_d;
    logic [AXIS_W-1:0]   pt_z_q, pt_z_d;

    logic                start;
    logic                last_point;
    logic [CNT_W-1:0]    clamped_size;
    box_t                start_box;
    logic [2:0]          step_oct;
    logic [BOX_W-1:0]    step_child;
    logic                unused_pad;

    assign unused_pad   = ^{i_near_bottom_left[15:0], i_far_top_right[15:0]};
    assign clamped_size = (i_point_cloud_size > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : i_point_cloud_size;
    assign start        = (state_q == ST_IDLE) && i_en && armed_q;
    assign last_point   = (idx_q == count_q - CNT_W'(1));

    octant_step u_step (
        .i_box   (box_q),
        .i_x     (pt_x_q),
        .i_y     (pt_y_q),
        .i_z     (pt_z_q),
        .o_oct   (step_oct),
        .o_child (step_child)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = (clamped_size == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:    state_d = ST_DESCEND;
            ST_DESCEND: if (level_q == LVL_W'(MAX_DEPTH - 1)) state_d = ST_EMIT;
            ST_EMIT:    if (i_ready) state_d = last_point ? ST_DONE : ST_LOAD;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_box       = '0;
        start_box.min_x = axis_field(i_near_bottom_left, X_HI);
        start_box.min_y = axis_field(i_near_bottom_left, Y_HI);
        start_box.min_z = axis_field(i_near_bottom_left, Z_HI);
        start_box.max_x = axis_field(i_far_top_right, X_HI);
        start_box.max_y = axis_field(i_far_top_right, Y_HI);
        start_box.max_z = axis_field(i_far_top_right, Z_HI);
    end

    always_comb begin
        armed_d  = armed_q;
        count_d  = count_q;
        idx_d    = idx_q;
        level_d  = level_q;
        code_d   = code_q;
        bounds_d = bounds_q;
        box_d    = box_q;
        pt_x_d   = pt_x_q;
        pt_y_d   = pt_y_q;
        pt_z_d   = pt_z_q;

        // A start consumes the arm; it only comes back once i_en is seen low.
        if (!i_en)      armed_d = 1'b1;
        else if (start) armed_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bounds_d = start_box;
                    count_d  = clamped_size;
                    idx_d    = '0;
                end
            end
            ST_LOAD: begin
                box_d   = bounds_q;
                level_d = '0;
                code_d  = '0;
                for (int k = 0; k < N_MAX; k++) begin
                    if (idx_q == CNT_W'(k)) begin
                        pt_x_d = i_points_x[16*k +: 16];
                        pt_y_d = i_points_y[16*k +: 16];
                        pt_z_d = i_points_z[16*k +: 16];
                    end
                end
            end
            ST_DESCEND: begin
                box_d   = step_child;
                level_d = level_q + LVL_W'(1);
                for (int d = 0; d < MAX_DEPTH; d++) begin
                    if (level_q == LVL_W'(d)) code_d[3*(MAX_DEPTH-1-d) +: 3] = step_oct;
                end
            end
            ST_EMIT: begin
                if (i_ready) idx_d = idx_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            armed_q <= 1'b1;
            count_q <= '0;
            idx_q   <= '0;
            level_q <= '0;
            code_q  <= '0;
        end else begin
            armed_q <= armed_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            code_q  <= code_d;
        end
    end

    // Geometry registers carry no reset; they are always reloaded before use.
    always_ff @(posedge i_clk) begin
        bounds_q <= bounds_d;
        box_q    <= box_d;
        pt_x_q   <= pt_x_d;
        pt_y_q   <= pt_y_d;
        pt_z_q   <= pt_z_d;
    end

    always_comb begin
        o_valid     = (state_q == ST_EMIT);
        o_busy      = (state_q != ST_IDLE);
        o_finish    = (state_q == ST_DONE);
        o_code      = code_q;
        o_point_idx = idx_q;
    end

endmodule

// File: tb/tb_octant_path_scheduler.sv
// Directed bench for octant_path_scheduler: single-point vector table plus
// multi-point, stall, clamp, mid-run reset and re-arm sequences.
module tb_octant_path_scheduler;

    logic          clk;
    logic          i_rst;
    logic          i_en;
    logic [7:0]    i_point_cloud_size;
    logic [111:0]  i_points_x;
    logic [111:0]  i_points_y;
    logic [111:0]  i_points_z;
    logic [63:0]   i_near_bottom_left;
    logic [63:0]   i_far_top_right;
    logic [41:0]   o_code;
    logic [7:0]    o_point_idx;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;
    logic          o_finish;

    int checks   = 0;
    int failures = 0;

    int px[7];
    int py[7];
    int pz[7];
    logic [63:0] g_nbl;
    logic [63:0] g_ftr;

    typedef struct {
        int         x;
        int         y;
        int         z;
        logic [63:0] nbl;
        logic [63:0] ftr;
        logic [2:0] l0;
        logic [2:0] l1;
    } vec_t;

    vec_t vecs[5];

    octant_path_scheduler dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_en               (i_en),
        .i_point_cloud_size (i_point_cloud_size),
        .i_points_x         (i_points_x),
        .i_points_y         (i_points_y),
        .i_points_z         (i_points_z),
        .i_near_bottom_left (i_near_bottom_left),
        .i_far_top_right    (i_far_top_right),
        .o_code             (o_code),
        .o_point_idx        (o_point_idx),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_busy             (o_busy),
        .o_finish           (o_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_box(input int x, input int y, input int z);
        return {16'(x), 16'(y), 16'(z), 16'h0000};
    endfunction

    // Reference octree descent on plain integers.
    function automatic logic [41:0] model_code(input int x, input int y, input int z,
                                               input logic [63:0] nbl, input logic [63:0] ftr);
        logic [41:0] c;
        int lo_x, lo_y, lo_z, hi_x, hi_y, hi_z, mx, my, mz;
        bit bx, by, bz;
        c    = '0;
        lo_x = int'($signed(nbl[63:48]));
        lo_y = int'($signed(nbl[47:32]));
        lo_z = int'($signed(nbl[31:16]));
        hi_x = int'($signed(ftr[63:48]));
        hi_y = int'($signed(ftr[47:32]));
        hi_z = int'($signed(ftr[31:16]));
        for (int d = 0; d < 14; d++) begin
            mx = (lo_x + hi_x) >>> 1;
            my = (lo_y + hi_y) >>> 1;
            mz = (lo_z + hi_z) >>> 1;
            bx = (x >= mx);
            by = (y >= my);
            bz = (z >= mz);
            if (bx) lo_x = mx; else hi_x = mx;
            if (by) lo_y = my; else hi_y = my;
            if (bz) lo_z = mz; else hi_z = mz;
            c[3*(13-d) +: 3] = {bx, by, bz};
        end
        return c;
    endfunction

    task automatic apply_inputs();
        for (int k = 0; k < 7; k++) begin
            i_points_x[16*k +: 16] = 16'(px[k]);
            i_points_y[16*k +: 16] = 16'(py[k]);
            i_points_z[16*k +: 16] = 16'(pz[k]);
        end
        i_near_bottom_left = g_nbl;
        i_far_top_right    = g_ftr;
    endtask

    // Starts a build and services it to completion, checking every emitted path.
    task automatic run_cloud(input int size, input int stall, input bit hold_en,
                             output int n_valid, output int busy_cyc, output int fin_cnt,
                             output int first_valid_edge, output int fin_edge,
                             output logic [41:0] first_code);
        int          edge_n;
        int          held;
        int          exp_idx;
        bit          done;
        logic [41:0] cap_code;
        logic [7:0]  cap_idx;
        edge_n = 0; held = 0; exp_idx = 0; done = 0;
        cap_code = '0; cap_idx = '0;
        n_valid = 0; busy_cyc = 0; fin_cnt = 0;
        first_valid_edge = -1; fin_edge = -1; first_code = '0;
        i_point_cloud_size = 8'(size);
        i_en    = 1'b1;
        i_ready = (stall == 0);
        while (!done && edge_n < 2000) begin
            tick();
            edge_n++;
            if (!hold_en) i_en = 1'b0;
            if (o_busy && !o_finish) busy_cyc++;
            if (o_finish) begin
                fin_cnt++;
                if (fin_edge < 0) fin_edge = edge_n;
            end
            if (o_valid) begin
                if (first_valid_edge < 0) begin
                    first_valid_edge = edge_n;
                    first_code = o_code;
                end
                if (held == 0) begin
                    cap_code = o_code;
                    cap_idx  = o_point_idx;
                end else begin
                    chk($sformatf("stall_code_p%0d", exp_idx), o_code, cap_code);
                    chk($sformatf("stall_idx_p%0d", exp_idx), o_point_idx, cap_idx);
                end
                if (held >= stall) begin
                    i_ready = 1'b1;
                    n_valid++;
                    chk($sformatf("idx_p%0d", exp_idx), o_point_idx, 8'(exp_idx));
                    if (exp_idx < 7)
                        chk($sformatf("code_p%0d", exp_idx), o_code,
                            model_code(px[exp_idx], py[exp_idx], pz[exp_idx], g_nbl, g_ftr));
                    exp_idx++;
                    held = 0;
                end else begin
                    i_ready = 1'b0;
                    held++;
                end
            end else begin
                i_ready = (stall == 0);
            end
            if (!o_busy && fin_cnt > 0) done = 1;
        end
        i_ready = 1'b0;
        if (!done) chk("run_timeout", 64'd0, 64'd1);
    endtask

    int          nv, bc, fc, fve, fe, cnt;
    logic [41:0] fcode;
    bit          found;

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_ready = 1'b0; i_point_cloud_size = '0;
        i_points_x = '0; i_points_y = '0; i_points_z = '0;
        g_nbl = mk_box(-25600, -25600, -25600);
        g_ftr = mk_box(25600, 25600, 25600);
        for (int k = 0; k < 7; k++) begin px[k] = 0; py[k] = 0; pz[k] = 0; end
        apply_inputs();

        vecs[0] = '{257, -42, -155, mk_box(-25600,-25600,-25600), mk_box(25600,25600,25600), 3'b100, 3'b011};
        vecs[1] = '{-10112, 7984, -313, mk_box(-25600,-25600,-25600), mk_box(25600,25600,25600), 3'b010, 3'b101};
        vecs[2] = '{100, 0, -1, mk_box(100,-25600,-25600), mk_box(100,25600,25600), 3'b110, 3'b101};
        vecs[3] = '{99, 0, -1, mk_box(100,-25600,-25600), mk_box(100,25600,25600), 3'b010, 3'b001};
        vecs[4] = '{30000, -30000, 0, mk_box(-25600,-25600,-25600), mk_box(25600,25600,25600), 3'b101, 3'b100};

        tick();
        tick();
        chk("rst_code", o_code, 42'd0);
        chk("rst_idx", o_point_idx, 8'd0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_finish", o_finish, 1'b0);
        i_rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 7; k++) begin px[k] = 0; py[k] = 0; pz[k] = 0; end
            px[0] = vecs[i].x; py[0] = vecs[i].y; pz[0] = vecs[i].z;
            g_nbl = vecs[i].nbl; g_ftr = vecs[i].ftr;
            apply_inputs();
            run_cloud(1, 0, 0, nv, bc, fc, fve, fe, fcode);
            chk($sformatf("vec%0d_latency", i), 64'(fve), 64'd16);
            chk($sformatf("vec%0d_l0", i), fcode[41:39], vecs[i].l0);
            chk($sformatf("vec%0d_l1", i), fcode[38:36], vecs[i].l1);
            chk($sformatf("vec%0d_nvalid", i), 64'(nv), 64'd1);
            chk($sformatf("vec%0d_finish_edge", i), 64'(fe), 64'd17);
            chk($sformatf("vec%0d_finish_cnt", i), 64'(fc), 64'd1);
            tick();
        end

        px = '{257, -10112, 25600, -25600, 30000, 1, -1};
        py = '{-42, 7984, -25600, 25599, -30000, 1, -1};
        pz = '{-155, -313, 0, -1, 12345, 1, -1};
        g_nbl = mk_box(-25600, -25600, -25600);
        g_ftr = mk_box(25600, 25600, 25600);
        apply_inputs();

        run_cloud(7, 0, 0, nv, bc, fc, fve, fe, fcode);
        chk("full_nvalid", 64'(nv), 64'd7);
        chk("full_busy", 64'(bc), 64'd112);
        chk("full_finish_cnt", 64'(fc), 64'd1);
        chk("full_finish_edge", 64'(fe), 64'd113);
        tick();

        run_cloud(7, 5, 0, nv, bc, fc, fve, fe, fcode);
        chk("stall_nvalid", 64'(nv), 64'd7);
        chk("stall_busy", 64'(bc), 64'd147);
        chk("stall_finish_cnt", 64'(fc), 64'd1);
        tick();

        run_cloud(0, 0, 0, nv, bc, fc, fve, fe, fcode);
        chk("empty_nvalid", 64'(nv), 64'd0);
        chk("empty_finish_edge", 64'(fe), 64'd1);
        chk("empty_finish_cnt", 64'(fc), 64'd1);
        tick();

        run_cloud(9, 0, 0, nv, bc, fc, fve, fe, fcode);
        chk("clamp_nvalid", 64'(nv), 64'd7);
        chk("clamp_busy", 64'(bc), 64'd112);
        chk("clamp_finish_cnt", 64'(fc), 64'd1);
        tick();

        // Reset while point 3 is descending.
        i_point_cloud_size = 8'd7;
        i_ready = 1'b1;
        i_en = 1'b1;
        tick();
        i_en = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (o_point_idx == 8'd3 && !o_valid && o_busy) found = 1;
            else tick();
        end
        chk("rstmid_reached_p3", found, 1'b1);
        for (int c = 0; c < 4; c++) tick();
        i_rst = 1'b1;
        tick();
        chk("rstmid_outputs", {o_code, o_point_idx, o_valid, o_busy, o_finish}, 64'd0);
        i_rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_finish || o_busy) cnt++;
        end
        chk("rstmid_no_finish", 64'(cnt), 64'd0);
        i_ready = 1'b0;

        // i_en held high through DONE must not retrigger.
        run_cloud(1, 0, 1, nv, bc, fc, fve, fe, fcode);
        chk("rearm_nvalid", 64'(nv), 64'd1);
        chk("rearm_finish_cnt", 64'(fc), 64'd1);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_busy) cnt++;
        end
        chk("rearm_no_restart", 64'(cnt), 64'd0);
        i_en = 1'b0;
        tick();
        i_en = 1'b1;
        tick();
        chk("rearm_restart_busy", o_busy, 1'b1);
        i_en = 1'b0;
        i_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (o_finish) found = 1;
        end
        chk("rearm_second_finish", found, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
